// File: rtl/knn_pair_sequencer.sv
// knn_pair_sequencer
// Control FSM for the KNN distance phase of the MLU array. Walks every
// (test image, reference image) pair, test outer and reference inner. For each
// pair it clears the MLU accumulators, then fetches and accumulates the image
// block by block, then presents one tagged distance result under a ready
// handshake.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   start           begin a run (only looked at while idle)
//   abort           synchronous cancel, back to idle without a done pulse
//   n_test, n_ref   pair counts for the run, saturated to COLD_IMGS / HOT_IMGS
//   ref_base        global index of reference 0 of the current HotBuffer load
//   asce_in         sort order for the run (1 = ascending)
//   out_ready       downstream accepts the current result
//   hot_idx         HotBuffer row = ref*BLK_PER_IMG + blk
//   cold_idx        ColdBuffer row = test*BLK_PER_IMG + blk
//   hot_read_en     buffer read enable, HotBuffer side
//   cold_read_en    buffer read enable, ColdBuffer side
//   clear_reg_acc   MLU accumulator clear
//   acc_en          MLU accumulate qualifier
//   symbol          MLU adder op, subtract while accumulating
//   sel_in          MLU input select (always the adder path)
//   sel_output      MLU output select
//   is_output       a result is valid for the current pair
//   index           sort index of the result (ref_base + ref)
//   test_id         test image of the result
//   asce            latched sort order
//   busy            high in every state except idle
//   done            one-cycle pulse when a run completes
//
// All outputs except the constant sel_in come straight from flops. Each
// output's next value is decoded from the next state and next counters, so it
// lines up with the state it belongs to.
module knn_pair_sequencer #(
  parameter int BLK_PER_IMG = 4,
  parameter int HOT_IMGS    = 16,
  parameter int COLD_IMGS   = 32,
  parameter int HOT_IDX_W   = 6,
  parameter int COLD_IDX_W  = 7,
  parameter int INDEX_W     = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            abort,
  input  logic [$clog2(COLD_IMGS+1)-1:0]  n_test,
  input  logic [$clog2(HOT_IMGS+1)-1:0]   n_ref,
  input  logic [INDEX_W-1:0]              ref_base,
  input  logic                            asce_in,
  input  logic                            out_ready,
  output logic [HOT_IDX_W-1:0]            hot_idx,
  output logic [COLD_IDX_W-1:0]           cold_idx,
  output logic                            hot_read_en,
  output logic                            cold_read_en,
  output logic                            clear_reg_acc,
  output logic                            acc_en,
  output logic [1:0]                      symbol,
  output logic                            sel_in,
  output logic [2:0]                      sel_output,
  output logic                            is_output,
  output logic [INDEX_W-1:0]              index,
  output logic [$clog2(COLD_IMGS)-1:0]    test_id,
  output logic                            asce,
  output logic                            busy,
  output logic                            done
);

  localparam int NT_W  = $clog2(COLD_IMGS + 1);
  localparam int NR_W  = $clog2(HOT_IMGS + 1);
  localparam int TID_W = $clog2(COLD_IMGS);
  localparam int RID_W = (HOT_IMGS > 1) ? $clog2(HOT_IMGS) : 1;
  localparam int BLK_W = (BLK_PER_IMG > 1) ? $clog2(BLK_PER_IMG) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_FETCH = 3'd2;
  localparam logic [2:0] S_ACC   = 3'd3;
  localparam logic [2:0] S_EMIT  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  // State and run-context registers.
  logic [2:0]         state_r;
  logic [NT_W-1:0]    n_test_r;
  logic [NR_W-1:0]    n_ref_r;
  logic [INDEX_W-1:0] ref_base_r;
  logic               asce_r;
  logic [TID_W-1:0]   test_r;
  logic [RID_W-1:0]   ref_r;
  logic [BLK_W-1:0]   blk_r;

  // Next values for the registers above.
  logic [2:0]         state_s;
  logic [NT_W-1:0]    n_test_s;
  logic [NR_W-1:0]    n_ref_s;
  logic [INDEX_W-1:0] ref_base_s;
  logic               asce_s;
  logic [TID_W-1:0]   test_s;
  logic [RID_W-1:0]   ref_s;
  logic [BLK_W-1:0]   blk_s;

  // Saturated run counts and end-of-loop flags.
  logic [NT_W-1:0]    n_test_sat_s;
  logic [NR_W-1:0]    n_ref_sat_s;
  logic               ref_last_s;
  logic               test_last_s;

  // Next values for the registered outputs.
  logic [HOT_IDX_W-1:0]  hot_idx_s;
  logic [COLD_IDX_W-1:0] cold_idx_s;
  logic                  read_en_s;
  logic                  clear_s;
  logic                  acc_en_s;
  logic [1:0]            symbol_s;
  logic [2:0]            sel_output_s;
  logic                  is_output_s;
  logic [INDEX_W-1:0]    index_s;
  logic [TID_W-1:0]      test_id_s;
  logic                  busy_s;
  logic                  done_s;

  assign sel_in = 1'b0;
  assign asce   = asce_r;

  // Clamp the requested counts to what the buffers actually hold.
  always_comb begin
    if (n_test > NT_W'(COLD_IMGS)) begin
      n_test_sat_s = NT_W'(COLD_IMGS);
    end else begin
      n_test_sat_s = n_test;
    end
    if (n_ref > NR_W'(HOT_IMGS)) begin
      n_ref_sat_s = NR_W'(HOT_IMGS);
    end else begin
      n_ref_sat_s = n_ref;
    end
    ref_last_s  = (NR_W'(ref_r) == (n_ref_r - NR_W'(1)));
    test_last_s = (NT_W'(test_r) == (n_test_r - NT_W'(1)));
  end

  // Next-state and counter logic; abort overrides every transition.
  always_comb begin
    state_s    = state_r;
    n_test_s   = n_test_r;
    n_ref_s    = n_ref_r;
    ref_base_s = ref_base_r;
    asce_s     = asce_r;
    test_s     = test_r;
    ref_s      = ref_r;
    blk_s      = blk_r;
    if (abort) begin
      state_s = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start) begin
            n_test_s   = n_test_sat_s;
            n_ref_s    = n_ref_sat_s;
            ref_base_s = ref_base;
            asce_s     = asce_in;
            test_s     = TID_W'(0);
            ref_s      = RID_W'(0);
            blk_s      = BLK_W'(0);
            if ((n_test_sat_s == NT_W'(0)) || (n_ref_sat_s == NR_W'(0))) begin
              state_s = S_DONE;
            end else begin
              state_s = S_CLEAR;
            end
          end else begin
            state_s = S_IDLE;
          end
        end
        S_CLEAR: begin
          blk_s   = BLK_W'(0);
          state_s = S_FETCH;
        end
        S_FETCH: begin
          state_s = S_ACC;
        end
        S_ACC: begin
          if (blk_r < BLK_W'(BLK_PER_IMG - 1)) begin
            blk_s   = blk_r + BLK_W'(1);
            state_s = S_FETCH;
          end else begin
            state_s = S_EMIT;
          end
        end
        S_EMIT: begin
          // The result stays presented until downstream takes it.
          if (out_ready) begin
            if (ref_last_s) begin
              ref_s = RID_W'(0);
              if (test_last_s) begin
                state_s = S_DONE;
              end else begin
                test_s  = test_r + TID_W'(1);
                state_s = S_CLEAR;
              end
            end else begin
              ref_s   = ref_r + RID_W'(1);
              state_s = S_CLEAR;
            end
          end else begin
            state_s = S_EMIT;
          end
        end
        S_DONE: begin
          state_s = S_IDLE;
        end
        default: begin
          state_s = S_IDLE;
        end
      endcase
    end
  end

  // Decode next-cycle outputs from the next state so they register in step with it.
  always_comb begin
    hot_idx_s    = HOT_IDX_W'(0);
    cold_idx_s   = COLD_IDX_W'(0);
    read_en_s    = 1'b0;
    clear_s      = 1'b0;
    acc_en_s     = 1'b0;
    symbol_s     = 2'b00;
    sel_output_s = 3'b000;
    is_output_s  = 1'b0;
    index_s      = INDEX_W'(0);
    test_id_s    = TID_W'(0);
    done_s       = 1'b0;
    busy_s       = (state_s != S_IDLE);
    case (state_s)
      S_CLEAR: begin
        clear_s = 1'b1;
      end
      S_FETCH, S_ACC: begin
        read_en_s  = 1'b1;
        hot_idx_s  = HOT_IDX_W'(ref_s) * HOT_IDX_W'(BLK_PER_IMG) + HOT_IDX_W'(blk_s);
        cold_idx_s = COLD_IDX_W'(test_s) * COLD_IDX_W'(BLK_PER_IMG) + COLD_IDX_W'(blk_s);
        if (state_s == S_ACC) begin
          acc_en_s = 1'b1;
          symbol_s = 2'b10;
        end else begin
          acc_en_s = 1'b0;
          symbol_s = 2'b00;
        end
      end
      S_EMIT: begin
        is_output_s  = 1'b1;
        sel_output_s = 3'b110;
        index_s      = ref_base_s + INDEX_W'(ref_s);
        test_id_s    = test_s;
      end
      S_DONE: begin
        done_s = 1'b1;
      end
      default: begin
        done_s = 1'b0;
      end
    endcase
  end

  // State, context and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= S_IDLE;
      n_test_r      <= NT_W'(0);
      n_ref_r       <= NR_W'(0);
      ref_base_r    <= INDEX_W'(0);
      asce_r        <= 1'b0;
      test_r        <= TID_W'(0);
      ref_r         <= RID_W'(0);
      blk_r         <= BLK_W'(0);
      hot_idx       <= HOT_IDX_W'(0);
      cold_idx      <= COLD_IDX_W'(0);
      hot_read_en   <= 1'b0;
      cold_read_en  <= 1'b0;
      clear_reg_acc <= 1'b0;
      acc_en        <= 1'b0;
      symbol        <= 2'b00;
      sel_output    <= 3'b000;
      is_output     <= 1'b0;
      index         <= INDEX_W'(0);
      test_id       <= TID_W'(0);
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state_r       <= state_s;
      n_test_r      <= n_test_s;
      n_ref_r       <= n_ref_s;
      ref_base_r    <= ref_base_s;
      asce_r        <= asce_s;
      test_r        <= test_s;
      ref_r         <= ref_s;
      blk_r         <= blk_s;
      hot_idx       <= hot_idx_s;
      cold_idx      <= cold_idx_s;
      hot_read_en   <= read_en_s;
      cold_read_en  <= read_en_s;
      clear_reg_acc <= clear_s;
      acc_en        <= acc_en_s;
      symbol        <= symbol_s;
      sel_output    <= sel_output_s;
      is_output     <= is_output_s;
      index         <= index_s;
      test_id       <= test_id_s;
      busy          <= busy_s;
      done          <= done_s;
    end
  end

endmodule

// File: tb/tb_knn_pair_sequencer.sv
// Self-checking bench for knn_pair_sequencer: a table of whole runs checked
// cycle by cycle against a position-in-run model, plus hand-written sequences
// for stall, abort, reset, start-while-busy and a 7-block configuration.
module tb_knn_pair_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, abort, asce_in, out_ready;
  logic [5:0]  n_test;
  logic [4:0]  n_ref;
  logic [31:0] ref_base;

  logic [5:0]  hot_idx;
  logic [6:0]  cold_idx;
  logic        hot_read_en, cold_read_en, clear_reg_acc, acc_en, sel_in;
  logic [1:0]  symbol;
  logic [2:0]  sel_output;
  logic        is_output, asce, busy, done;
  logic [31:0] index;
  logic [4:0]  test_id;

  // Second instance: 7 blocks per image, 8 references.
  logic        start7, out_ready7;
  logic [5:0]  n_test7;
  logic [3:0]  n_ref7;
  logic [31:0] ref_base7;
  logic [5:0]  hot_idx7;
  logic [7:0]  cold_idx7;
  logic        hot_read_en7, cold_read_en7, clear_reg_acc7, acc_en7, sel_in7;
  logic [1:0]  symbol7;
  logic [2:0]  sel_output7;
  logic        is_output7, asce7, busy7, done7;
  logic [31:0] index7;
  logic [4:0]  test_id7;

  knn_pair_sequencer u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .n_test(n_test), .n_ref(n_ref), .ref_base(ref_base),
    .asce_in(asce_in), .out_ready(out_ready),
    .hot_idx(hot_idx), .cold_idx(cold_idx),
    .hot_read_en(hot_read_en), .cold_read_en(cold_read_en),
    .clear_reg_acc(clear_reg_acc), .acc_en(acc_en), .symbol(symbol),
    .sel_in(sel_in), .sel_output(sel_output), .is_output(is_output),
    .index(index), .test_id(test_id), .asce(asce), .busy(busy), .done(done)
  );

  knn_pair_sequencer #(
    .BLK_PER_IMG(7), .HOT_IMGS(8), .COLD_IMGS(32),
    .HOT_IDX_W(6), .COLD_IDX_W(8), .INDEX_W(32)
  ) u_dut7 (
    .clk(clk), .rst(rst), .start(start7), .abort(abort),
    .n_test(n_test7), .n_ref(n_ref7), .ref_base(ref_base7),
    .asce_in(asce_in), .out_ready(out_ready7),
    .hot_idx(hot_idx7), .cold_idx(cold_idx7),
    .hot_read_en(hot_read_en7), .cold_read_en(cold_read_en7),
    .clear_reg_acc(clear_reg_acc7), .acc_en(acc_en7), .symbol(symbol7),
    .sel_in(sel_in7), .sel_output(sel_output7), .is_output(is_output7),
    .index(index7), .test_id(test_id7), .asce(asce7), .busy(busy7), .done(done7)
  );

  logic [63:0] act_vec;
  logic [64:0] act7_vec;
  assign act_vec = {busy, done, clear_reg_acc, hot_read_en, cold_read_en, acc_en,
                    symbol, sel_in, sel_output, is_output, hot_idx, cold_idx,
                    index, test_id, asce};
  assign act7_vec = {busy7, done7, clear_reg_acc7, hot_read_en7, cold_read_en7, acc_en7,
                     symbol7, sel_in7, sel_output7, is_output7, hot_idx7, cold_idx7,
                     index7, test_id7, asce7};

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [5:0]  nt;
    logic [4:0]  nr;
    logic [31:0] base;
    logic        asc;
    int          eff_t;
    int          eff_r;
    int          done_cyc;
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [64:0] a, input logic [64:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, a, e);
    end
  endtask

  function automatic logic [63:0] pk(input logic bz, input logic dn, input logic cl,
                                     input logic hr, input logic cr, input logic ac,
                                     input logic [1:0] sy, input logic [2:0] so,
                                     input logic io, input logic [5:0] hi,
                                     input logic [6:0] ci, input logic [31:0] ix,
                                     input logic [4:0] ti, input logic as);
    return {bz, dn, cl, hr, cr, ac, sy, 1'b0, so, io, hi, ci, ix, ti, as};
  endfunction

  // Expected outputs at cycle c of a run with out_ready high (10 cycles per pair).
  function automatic logic [63:0] exp_at(input int c, input int tn, input int rn,
                                         input int d, input logic [31:0] base,
                                         input logic as);
    int p, t, r, off, blk;
    logic ev;
    if (c > d) return pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0,
                         6'd0, 7'd0, 32'd0, 5'd0, as);
    if (c == d) return pk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0,
                          6'd0, 7'd0, 32'd0, 5'd0, as);
    p   = (c - 1) / 10;
    t   = p / rn;
    r   = p % rn;
    off = (c - 1) % 10;
    if (off == 0) return pk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0,
                            6'd0, 7'd0, 32'd0, 5'd0, as);
    if (off <= 8) begin
      blk = (off - 1) / 2;
      ev  = (off % 2 == 0);
      return pk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, ev, ev ? 2'b10 : 2'b00, 3'b000, 1'b0,
                6'(r * 4 + blk), 7'(t * 4 + blk), 32'd0, 5'd0, as);
    end
    return pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b110, 1'b1,
              6'd0, 7'd0, base + 32'(r), 5'(t), as);
  endfunction

  task automatic start_run(input logic [5:0] nt, input logic [4:0] nr,
                           input logic [31:0] b, input logic as);
    n_test   = nt;
    n_ref    = nr;
    ref_base = b;
    asce_in  = as;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  initial begin
    int hs, dn_cnt, io_cnt;
    logic [31:0] ei;
    logic        eo;

    vecs[0] = '{6'd1,  5'd1,  32'd100,        1'b0, 1,  1,  11};
    vecs[1] = '{6'd2,  5'd3,  32'd0,          1'b1, 2,  3,  61};
    vecs[2] = '{6'd1,  5'd0,  32'd5,          1'b1, 0,  0,  1};
    vecs[3] = '{6'd0,  5'd4,  32'd5,          1'b0, 0,  0,  1};
    vecs[4] = '{6'd1,  5'd20, 32'h10,         1'b0, 1,  16, 161};
    vecs[5] = '{6'd40, 5'd1,  32'd0,          1'b1, 32, 1,  321};
    vecs[6] = '{6'd3,  5'd2,  32'hFFFF_FFFF,  1'b1, 3,  2,  61};

    rst = 1'b1; start = 1'b0; abort = 1'b0; asce_in = 1'b0; out_ready = 1'b1;
    n_test = 6'd0; n_ref = 5'd0; ref_base = 32'd0;
    start7 = 1'b0; out_ready7 = 1'b1; n_test7 = 6'd0; n_ref7 = 4'd0; ref_base7 = 32'd0;
    tick(); tick(); tick();
    chk("reset_outputs", {1'b0, act_vec}, 65'd0);
    chk("reset_outputs7", act7_vec, 65'd0);
    rst = 1'b0;
    tick();

    // Whole runs with out_ready high, checked every cycle.
    for (int i = 0; i < 7; i++) begin
      start_run(vecs[i].nt, vecs[i].nr, vecs[i].base, vecs[i].asc);
      for (int c = 1; c <= vecs[i].done_cyc + 1; c++) begin
        chk($sformatf("vec%0d_c%0d", i, c), {1'b0, act_vec},
            {1'b0, exp_at(c, vecs[i].eff_t, vecs[i].eff_r, vecs[i].done_cyc,
                          vecs[i].base, vecs[i].asc)});
        tick();
      end
    end

    // Stall: out_ready low for the first 5 EMIT cycles of pair 0.
    out_ready = 1'b0;
    hs = 0;
    start_run(6'd1, 5'd2, 32'd7, 1'b0);
    for (int c = 1; c <= 27; c++) begin
      out_ready = (c >= 15);
      eo = ((c >= 10) && (c <= 15)) || (c == 25);
      ei = (c == 25) ? 32'd8 : (eo ? 32'd7 : 32'd0);
      chk($sformatf("stall_c%0d", c), {31'd0, is_output, index, done},
          {31'd0, eo, ei, (c == 26)});
      if (is_output && out_ready) hs++;
      tick();
    end
    chk("stall_handshakes", 65'(hs), 65'd2);

    // Abort in an ACC cycle.
    out_ready = 1'b1;
    start_run(6'd1, 5'd1, 32'd0, 1'b1);
    tick(); tick();
    chk("abort_in_acc_state", {64'd0, acc_en}, 65'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_idle", {1'b0, act_vec}, {1'b0, exp_at(2, 1, 1, 1, 32'd0, 1'b1)});
    dn_cnt = 0; io_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      if (done) dn_cnt++;
      if (is_output) io_cnt++;
      tick();
    end
    chk("abort_no_done", 65'(dn_cnt), 65'd0);
    chk("abort_no_output", 65'(io_cnt), 65'd0);

    // start while busy is ignored; latched asce and counts are kept.
    start_run(6'd1, 5'd1, 32'd50, 1'b0);
    for (int c = 1; c <= 12; c++) begin
      if (c == 5) begin
        start = 1'b1; n_ref = 5'd3; ref_base = 32'd99; asce_in = 1'b1;
      end else begin
        start = 1'b0;
      end
      chk($sformatf("busy_start_c%0d", c), {1'b0, act_vec},
          {1'b0, exp_at(c, 1, 1, 11, 32'd50, 1'b0)});
      tick();
    end

    // Abort wins over out_ready in EMIT.
    start_run(6'd1, 5'd1, 32'd3, 1'b1);
    for (int c = 1; c < 10; c++) tick();
    chk("emit_before_abort", {1'b0, act_vec}, {1'b0, exp_at(10, 1, 1, 11, 32'd3, 1'b1)});
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_emit_idle", {1'b0, act_vec}, {1'b0, exp_at(12, 1, 1, 11, 32'd3, 1'b1)});
    tick();
    chk("abort_emit_no_done", {1'b0, act_vec}, {1'b0, exp_at(12, 1, 1, 11, 32'd3, 1'b1)});

    // Reset mid-run clears everything including asce.
    start_run(6'd2, 5'd2, 32'd0, 1'b1);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_midrun", {1'b0, act_vec}, 65'd0);
    tick();
    chk("rst_midrun_stay", {1'b0, act_vec}, 65'd0);

    // 7-block instance: 16 cycles per pair, index wraps past 2^32-1.
    asce_in = 1'b1;
    n_test7 = 6'd1; n_ref7 = 4'd2; ref_base7 = 32'hFFFF_FFFF;
    start7 = 1'b1;
    tick();
    start7 = 1'b0;
    for (int c = 1; c <= 34; c++) begin
      eo = (c == 16) || (c == 32);
      ei = (c == 16) ? 32'hFFFF_FFFF : 32'd0;
      chk($sformatf("blk7_c%0d", c), {31'd0, is_output7, index7, done7},
          {31'd0, eo, ei, (c == 33)});
      if (c == 18)
        chk("blk7_fetch_pair1", act7_vec,
            {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 3'b000, 1'b0,
             6'd7, 8'd0, 32'd0, 5'd0, 1'b1});
      if (c == 31)
        chk("blk7_acc_last", {59'd0, hot_idx7}, 65'd13);
      tick();
    end
    chk("blk7_idle", act7_vec, {64'd0, 1'b1});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/knn_pair_sequencer.md
# knn_pair_sequencer

Parametrised control FSM for the KNN distance phase of the MLU array: walks every (test image, reference image) pair held in the ColdBuffer and HotBuffer, drives buffer read indices and MLU control (clear, accumulate, output, sort index) block by block, and emits one tagged distance result per pair under a ready handshake. It replaces hand-sequenced stimulus with a reusable controller. It sits between the buffer pair and the 16 MLU instances. Layout, pair count and sort order are configurable rather than fixed at 4 blocks × 16 refs × 32 tests.

## Interface
- BLK_PER_IMG, 4: 256-element buffer rows per image.
- HOT_IMGS, 16: reference images resident in HotBuffer.
- COLD_IMGS, 32: test images resident in ColdBuffer.
- HOT_IDX_W, 6: HotBuffer row index width, ≥ clog2(HOT_IMGS·BLK_PER_IMG).
- COLD_IDX_W, 7: ColdBuffer row index width, ≥ clog2(COLD_IMGS·BLK_PER_IMG).
- INDEX_W, 32: sort-index width (MLU Misc index).
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a run; sampled only in IDLE.
- abort  in  1  synchronous cancel; returns to IDLE next cycle without done.
- n_test  in  clog2(COLD_IMGS+1)  test images to process; values > COLD_IMGS saturate to COLD_IMGS.
- n_ref  in  clog2(HOT_IMGS+1)  reference images to process; values > HOT_IMGS saturate to HOT_IMGS.
- ref_base  in  INDEX_W  global index of reference 0 of this HotBuffer load.
- asce_in  in  1  sort order for the run (1 = ascending).
- out_ready  in  1  downstream accepts the current result.
- hot_idx  out  HOT_IDX_W  HotBuffer row = ref·BLK_PER_IMG + blk.
- cold_idx  out  COLD_IDX_W  ColdBuffer row = test·BLK_PER_IMG + blk.
- hot_read_en, cold_read_en  out  1  buffer read enables.
- clear_reg_acc  out  1  clear MLU accumulators.
- acc_en  out  1  MLU accumulate qualifier.
- symbol  out  2  adder op; 2'b10 (subtract) whenever acc_en, else 2'b00.
- sel_in  out  1  constant 0 (adder path).
- sel_output  out  3  3'b110 during EMIT, else 3'b000.
- is_output  out  1  result valid for the current pair.
- index  out  INDEX_W  ref_base + ref, modulo 2^INDEX_W.
- test_id  out  clog2(COLD_IMGS)  current test image.
- asce  out  1  latched asce_in.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at run completion.

## Operation
- States: IDLE, CLEAR, FETCH, ACC, EMIT, DONE.
- IDLE: on start, latch saturated n_test/n_ref, ref_base, asce_in; zero test/ref/blk counters. If either count is 0 → DONE, else → CLEAR.
- CLEAR: clear_reg_acc=1 for one cycle; blk=0 → FETCH.
- FETCH: read_en both 1, hot_idx/cold_idx driven from current ref/test/blk → ACC.
- ACC: read_en held 1, indices held, acc_en=1, symbol=2'b10. If blk < BLK_PER_IMG−1: blk++ → FETCH; else → EMIT.
- EMIT: is_output=1, sel_output=3'b110, index and test_id stable; held until out_ready. On out_ready: advance ref; on ref wrap (ref==n_ref−1) set ref=0 and advance test. If this was the last pair → DONE, else → CLEAR.
- DONE: done=1 for one cycle → IDLE.
- Pair order: test outer, ref inner.
- start while busy: ignored. abort has priority over every transition, including out_ready in EMIT. rst has priority over abort.
- Outputs not listed as active in a state are 0.

## Timing
- Reset value of every output: 0 (asce=0, symbol=2'b00, index=0, test_id=0, busy=0, done=0).
- start sampled in cycle 0 → CLEAR in cycle 1. Buffer data is valid in the cycle after FETCH, i.e. in ACC.
- Cycles per pair with out_ready tied high: 1 + 2·BLK_PER_IMG + 1 (=10 at default).
- Run length with out_ready high: n_test·n_ref·(2·BLK_PER_IMG+2) cycles, plus 1 DONE cycle.
- Zero count: done is asserted in cycle 1.
- is_output stays high and index, test_id and asce stay stable for every cycle of EMIT until the handshake completes. Exactly one result is transferred per handshake.
- abort or rst mid-run: next cycle all outputs are at reset values (asce keeps its latched value on abort), busy=0, no done pulse.

## Test plan
- Default parameters, n_test=1, n_ref=1, ref_base=100, out_ready=1 → CLEAR@1; hot/cold_idx 0,1,2,3 in FETCH/ACC pairs; is_output@10 with index=100; done@11.
- n_test=2, n_ref=3, ref_base=0 → 6 EMITs in order (test,ref)=(0,0),(0,1),(0,2),(1,0),(1,1),(1,2); cold_idx rows 4–7 on test 1; done at cycle 61.
- out_ready held low for 5 cycles during the first EMIT → is_output and index held 5 extra cycles; one result accepted; total run length +5.
- n_ref=0 → done@1, no is_output. n_ref=20 with HOT_IMGS=16 → exactly 16 results per test.
- abort asserted in an ACC cycle → next cycle IDLE, all outputs 0, no done pulse. start while busy → ignored.
- BLK_PER_IMG=7, HOT_IMGS=8, ref_base=2^32−1, n_ref=2 → indices wrap to 0xFFFFFFFF then 0x00000000; 16 cycles per pair.
